// File: rtl/csr_defines.sv
`default_nettype none
// ============================================================================
// Module   : csr_defines
// Purpose  : Exception codes, flag bit indices and commit FSM encoding shared
//            by the write-back commit logic and the CSR file.
// Revision : 1.0
// ============================================================================
package csr_defines;

  localparam int EXC_FLAGS_W = 7;

  localparam int EXCF_INT  = 0;
  localparam int EXCF_ADEF = 1;
  localparam int EXCF_INE  = 2;
  localparam int EXCF_SYS  = 3;
  localparam int EXCF_BRK  = 4;
  localparam int EXCF_ALE  = 5;
  localparam int EXCF_ADEM = 6;

  localparam logic [5:0] ECODE_INT  = 6'h00;
  localparam logic [5:0] ECODE_ADEF = 6'h08;
  localparam logic [5:0] ECODE_ADEM = 6'h08;
  localparam logic [5:0] ECODE_ALE  = 6'h09;
  localparam logic [5:0] ECODE_SYS  = 6'h0B;
  localparam logic [5:0] ECODE_BRK  = 6'h0C;
  localparam logic [5:0] ECODE_INE  = 6'h0D;

  localparam logic [8:0] ESUBCODE_ADEM = 9'd1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_REDIR = 1'b1
  } commit_state_e;

endpackage : csr_defines
`default_nettype wire

// File: rtl/exc_prio_enc.sv
`default_nettype none
// ============================================================================
// Module   : exc_prio_enc
// Purpose  : Fixed-priority encoder from raw exception flags to Ecode/EsubCode.
// Revision : 1.0
// ============================================================================
module exc_prio_enc
  import csr_defines::*;
(
  input  logic [6:0] i_flags,
  output logic [5:0] o_ecode,
  output logic [8:0] o_esubcode,
  output logic       o_any
);

  always_comb begin
    o_ecode    = 6'h00;
    o_esubcode = 9'd0;
    o_any      = |i_flags;
    if      (i_flags[EXCF_INT])  o_ecode = ECODE_INT;
    else if (i_flags[EXCF_ADEF]) o_ecode = ECODE_ADEF;
    else if (i_flags[EXCF_INE])  o_ecode = ECODE_INE;
    else if (i_flags[EXCF_SYS])  o_ecode = ECODE_SYS;
    else if (i_flags[EXCF_BRK])  o_ecode = ECODE_BRK;
    else if (i_flags[EXCF_ALE])  o_ecode = ECODE_ALE;
    else if (i_flags[EXCF_ADEM]) begin
      o_ecode    = ECODE_ADEM;
      o_esubcode = ESUBCODE_ADEM;
    end
  end

endmodule : exc_prio_enc
`default_nettype wire

// File: rtl/wb_exc_commit.sv
`default_nettype none
// ============================================================================
// Module   : wb_exc_commit
// Purpose  : WB-stage exception/ERTN commit, held flush and pre-IF redirect.
// Revision : 1.0
// ============================================================================
module wb_exc_commit
  import csr_defines::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wb_valid,
  input  logic [31:0]      i_wb_pc,
  input  logic [6:0]       i_wb_exc_flags,
  input  logic             i_wb_is_ertn,
  input  logic [31:0]      i_ex_entry,
  input  logic [31:0]      i_ertn_pc,
  output logic             o_wb_ex,
  output logic [5:0]       o_wb_ecode,
  output logic [8:0]       o_wb_esubcode,
  output logic [31:0]      o_wb_epc,
  output logic             o_ertn_flush,
  output logic             o_wb_commit_ok,
  output logic             o_flush_all,
  output logic             o_redirect_valid,
  output logic [31:0]      o_redirect_pc,
  input  logic             i_redirect_ready,
  output logic [CNT_W-1:0] o_exc_count
);

  commit_state_e    r_state;
  logic [31:0]      r_redirect_pc;
  logic             r_redirect_valid;
  logic [CNT_W-1:0] r_exc_count;

  logic       w_idle;
  logic       w_any;
  logic [5:0] w_ecode;
  logic [8:0] w_esubcode;
  logic       w_take_ex;
  logic       w_take_ertn;

  exc_prio_enc u_prio (
    .i_flags    (i_wb_exc_flags),
    .o_ecode    (w_ecode),
    .o_esubcode (w_esubcode),
    .o_any      (w_any)
  );

  // rst_n in w_idle keeps the commit-cycle outputs quiet while reset is held.
  assign w_idle      = rst_n & (r_state == ST_IDLE);
  assign w_take_ex   = w_idle & i_wb_valid & w_any;
  assign w_take_ertn = w_idle & i_wb_valid & i_wb_is_ertn & ~w_any;

  assign o_wb_ex          = w_take_ex;
  assign o_ertn_flush     = w_take_ertn;
  assign o_wb_ecode       = w_take_ex ? w_ecode    : 6'h00;
  assign o_wb_esubcode    = w_take_ex ? w_esubcode : 9'd0;
  assign o_wb_epc         = w_idle ? i_wb_pc : 32'h0;
  assign o_wb_commit_ok   = w_idle & i_wb_valid & ~w_any;
  assign o_flush_all      = w_take_ex | w_take_ertn | r_redirect_valid;
  assign o_redirect_valid = r_redirect_valid;
  assign o_redirect_pc    = r_redirect_pc;
  assign o_exc_count      = r_exc_count;

  // ERA is sampled in the commit cycle, before the CSR file applies ertn_flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= ST_IDLE;
      r_redirect_pc    <= 32'h0;
      r_redirect_valid <= 1'b0;
      r_exc_count      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_take_ex || w_take_ertn) begin
            r_state          <= ST_REDIR;
            r_redirect_valid <= 1'b1;
            r_redirect_pc    <= w_take_ex ? i_ex_entry : i_ertn_pc;
          end
          if (w_take_ex) begin
            r_exc_count <= r_exc_count + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_REDIR: begin
          if (i_redirect_ready) begin
            r_state          <= ST_IDLE;
            r_redirect_valid <= 1'b0;
          end
        end
        default: begin
          r_state          <= ST_IDLE;
          r_redirect_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule : wb_exc_commit
`default_nettype wire

// File: tb/tb_wb_exc_commit.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_exc_commit
// Purpose  : Self-checking bench for wb_exc_commit with a cause-table model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_wb_exc_commit;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wb_valid;
  logic [31:0]   wb_pc;
  logic [6:0]    wb_flags;
  logic          wb_is_ertn;
  logic [31:0]   ex_entry;
  logic [31:0]   ertn_pc;
  logic          ready;
  logic          wb_ex;
  logic [5:0]    ecode;
  logic [8:0]    esub;
  logic [31:0]   epc;
  logic          ertn_flush;
  logic          commit_ok;
  logic          flush_all;
  logic          rvalid;
  logic [31:0]   rpc;
  logic [CW-1:0] cnt;

  int vectors    = 0;
  int miscompares = 0;

  // Reference state: a redirect is outstanding, its target, exceptions taken.
  bit          m_redir;
  logic [31:0] m_pc;
  int          m_cnt;

  always #5 clk = ~clk;

  wb_exc_commit #(.CNT_W(CW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_wb_valid       (wb_valid),
    .i_wb_pc          (wb_pc),
    .i_wb_exc_flags   (wb_flags),
    .i_wb_is_ertn     (wb_is_ertn),
    .i_ex_entry       (ex_entry),
    .i_ertn_pc        (ertn_pc),
    .o_wb_ex          (wb_ex),
    .o_wb_ecode       (ecode),
    .o_wb_esubcode    (esub),
    .o_wb_epc         (epc),
    .o_ertn_flush     (ertn_flush),
    .o_wb_commit_ok   (commit_ok),
    .o_flush_all      (flush_all),
    .o_redirect_valid (rvalid),
    .o_redirect_pc    (rpc),
    .i_redirect_ready (ready),
    .o_exc_count      (cnt)
  );

  // Causes listed from highest priority down: the lowest set flag wins.
  function automatic logic [5:0] ref_ecode(input logic [6:0] f);
    logic [5:0] lut [7];
    lut = '{6'h00, 6'h08, 6'h0D, 6'h0B, 6'h0C, 6'h09, 6'h08};
    for (int i = 0; i < 7; i++) if (f[i]) return lut[i];
    return 6'h00;
  endfunction

  function automatic logic [8:0] ref_esub(input logic [6:0] f);
    for (int i = 0; i < 7; i++) if (f[i]) return (i == 6) ? 9'd1 : 9'd0;
    return 9'd0;
  endfunction

  function automatic logic [CW-1:0] ref_cnt();
    return CW'(m_cnt % (1 << CW));
  endfunction

  task automatic drive(input logic v, input logic [31:0] pc, input logic [6:0] f,
                       input logic e, input logic [31:0] ent, input logic [31:0] era,
                       input logic rdy);
    wb_valid = v; wb_pc = pc; wb_flags = f; wb_is_ertn = e;
    ex_entry = ent; ertn_pc = era; ready = rdy;
  endtask

  // Advance one clock from a negedge, updating the model from the applied inputs.
  task automatic tick();
    bit te, tr;
    te = wb_valid && (wb_flags != 0);
    tr = wb_valid && wb_is_ertn && (wb_flags == 0);
    @(posedge clk);
    if (!m_redir) begin
      if (te || tr) begin
        m_redir = 1'b1;
        m_pc    = te ? ex_entry : ertn_pc;
        if (te) m_cnt++;
      end
    end else if (ready) begin
      m_redir = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 32'h1c000100, 7'h08, 1'b0, 32'h1c008000, 32'h0, 1'b1);
    m_redir = 1'b0; m_pc = 32'h0; m_cnt = 0;
    repeat (2) @(negedge clk);
    vectors++; if (wb_ex !== 1'b0) begin miscompares++; $display("FAIL reset_wb_ex: got %b expected 0", wb_ex); end
    vectors++; if (flush_all !== 1'b0) begin miscompares++; $display("FAIL reset_flush: got %b expected 0", flush_all); end
    vectors++; if (commit_ok !== 1'b0) begin miscompares++; $display("FAIL reset_commit_ok: got %b expected 0", commit_ok); end
    vectors++; if (rvalid !== 1'b0 || rpc !== 32'h0) begin miscompares++; $display("FAIL reset_redirect: got %b/%h expected 0/0", rvalid, rpc); end
    vectors++; if (cnt !== '0) begin miscompares++; $display("FAIL reset_count: got %0d expected 0", cnt); end
    drive(1'b0, 32'h0, 7'h0, 1'b0, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_syscall();
    drive(1'b1, 32'h1c000100, 7'h08, 1'b0, 32'h1c008000, 32'h0, 1'b1);
    #1;
    vectors++; if (wb_ex !== 1'b1 || ecode !== 6'h0B || esub !== 9'd0) begin miscompares++; $display("FAIL sys_commit: got ex=%b ecode=%h sub=%h expected 1/0b/0", wb_ex, ecode, esub); end
    vectors++; if (epc !== 32'h1c000100 || commit_ok !== 1'b0 || flush_all !== 1'b1) begin miscompares++; $display("FAIL sys_epc: got epc=%h ok=%b fl=%b expected 1c000100/0/1", epc, commit_ok, flush_all); end
    vectors++; if (rvalid !== 1'b0) begin miscompares++; $display("FAIL sys_early_redirect: got %b expected 0", rvalid); end
    tick();
    drive(1'b0, 32'h0, 7'h0, 1'b0, 32'h0, 32'h0, 1'b1);
    #1;
    vectors++; if (rvalid !== 1'b1 || rpc !== m_pc) begin miscompares++; $display("FAIL sys_redirect: got %b/%h expected 1/%h", rvalid, rpc, m_pc); end
    vectors++; if (cnt !== ref_cnt()) begin miscompares++; $display("FAIL sys_count: got %0d expected %0d", cnt, ref_cnt()); end
    tick();
    #1;
    vectors++; if (rvalid !== 1'b0 || flush_all !== 1'b0) begin miscompares++; $display("FAIL sys_one_cycle: got %b/%b expected 0/0", rvalid, flush_all); end
  endtask

  task automatic test_priority();
    logic [6:0] pat [3];
    pat = '{7'h41, 7'h60, 7'h40};
    foreach (pat[k]) begin
      drive(1'b1, 32'h1c000200 + 32'(k * 4), pat[k], 1'b0, 32'h1c008000, 32'h0, 1'b1);
      #1;
      vectors++; if (ecode !== ref_ecode(pat[k]) || esub !== ref_esub(pat[k])) begin miscompares++; $display("FAIL prio_%h: got %h/%h expected %h/%h", pat[k], ecode, esub, ref_ecode(pat[k]), ref_esub(pat[k])); end
      tick();
      drive(1'b0, 32'h0, 7'h0, 1'b0, 32'h0, 32'h0, 1'b1);
      tick();
    end
  endtask

  task automatic test_ertn();
    int c0;
    c0 = m_cnt;
    drive(1'b1, 32'h1c000300, 7'h00, 1'b1, 32'h1c008000, 32'h1c000204, 1'b1);
    #1;
    vectors++; if (ertn_flush !== 1'b1 || wb_ex !== 1'b0 || commit_ok !== 1'b1) begin miscompares++; $display("FAIL ertn_commit: got fl=%b ex=%b ok=%b expected 1/0/1", ertn_flush, wb_ex, commit_ok); end
    tick();
    drive(1'b0, 32'h0, 7'h0, 1'b0, 32'h0, 32'h0, 1'b1);
    #1;
    vectors++; if (rvalid !== 1'b1 || rpc !== 32'h1c000204) begin miscompares++; $display("FAIL ertn_redirect: got %b/%h expected 1/1c000204", rvalid, rpc); end
    vectors++; if (cnt !== CW'(c0 % (1 << CW))) begin miscompares++; $display("FAIL ertn_count: got %0d expected %0d", cnt, c0 % (1 << CW)); end
    tick();
    drive(1'b1, 32'h1c000304, 7'h10, 1'b1, 32'h1c008000, 32'h1c000204, 1'b1);
    #1;
    vectors++; if (wb_ex !== 1'b1 || ertn_flush !== 1'b0 || ecode !== ref_ecode(7'h10)) begin miscompares++; $display("FAIL ertn_vs_brk: got ex=%b fl=%b ecode=%h expected 1/0/%h", wb_ex, ertn_flush, ecode, ref_ecode(7'h10)); end
    tick();
    drive(1'b0, 32'h0, 7'h0, 1'b0, 32'h0, 32'h0, 1'b1);
    #1;
    vectors++; if (rpc !== m_pc) begin miscompares++; $display("FAIL brk_redirect_pc: got %h expected %h", rpc, m_pc); end
    tick();
  endtask

  task automatic test_backpressure();
    int held;
    held = 0;
    drive(1'b1, 32'h1c000400, 7'h08, 1'b0, 32'h1c00a000, 32'h0, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h1c000404, 7'h04, 1'b0, 32'h1c00b000, 32'h0, (i == 3));
      #1;
      if (rvalid === 1'b1 && flush_all === 1'b1) held++;
      vectors++; if (wb_ex !== 1'b0 || commit_ok !== 1'b0 || rpc !== 32'h1c00a000) begin miscompares++; $display("FAIL bp_hold_%0d: got ex=%b ok=%b pc=%h expected 0/0/1c00a000", i, wb_ex, commit_ok, rpc); end
      tick();
    end
    vectors++; if (held != 4) begin miscompares++; $display("FAIL bp_held_cycles: got %0d expected 4", held); end
    drive(1'b0, 32'h0, 7'h0, 1'b0, 32'h0, 32'h0, 1'b1);
    #1;
    vectors++; if (rvalid !== 1'b0 || flush_all !== 1'b0) begin miscompares++; $display("FAIL bp_release: got %b/%b expected 0/0", rvalid, flush_all); end
    tick();
  endtask

  task automatic test_async_reset();
    drive(1'b1, 32'h1c000500, 7'h01, 1'b0, 32'h1c00c000, 32'h0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 7'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    #3;
    vectors++; if (rvalid !== 1'b1) begin miscompares++; $display("FAIL ar_pre_redirect: got %b expected 1", rvalid); end
    rst_n = 1'b0;
    m_redir = 1'b0; m_pc = 32'h0; m_cnt = 0;
    #1;
    vectors++; if (rvalid !== 1'b0 || flush_all !== 1'b0) begin miscompares++; $display("FAIL ar_drop: got %b/%b expected 0/0", rvalid, flush_all); end
    vectors++; if (cnt !== '0) begin miscompares++; $display("FAIL ar_count: got %0d expected 0", cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    ready = 1'b1;
    drive(1'b1, 32'h1c000504, 7'h20, 1'b0, 32'h1c00d000, 32'h0, 1'b1);
    tick();
    drive(1'b0, 32'h0, 7'h0, 1'b0, 32'h0, 32'h0, 1'b1);
    #1;
    vectors++; if (cnt !== CW'(1) || rvalid !== 1'b1) begin miscompares++; $display("FAIL ar_after: got cnt=%0d rv=%b expected 1/1", cnt, rvalid); end
    tick();
  endtask

  task automatic test_wrap_idle();
    logic [CW-1:0] start;
    start = ref_cnt();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, $urandom, 7'(1 << (i % 7)), 1'b0, $urandom, 32'h0, 1'b1);
      tick();
      drive(1'b0, 32'h0, 7'h0, 1'b0, 32'h0, 32'h0, 1'b1);
      tick();
    end
    #1;
    vectors++; if (cnt !== start || m_cnt % 16 != start) begin miscompares++; $display("FAIL wrap_count: got %0d expected %0d", cnt, start); end
    drive(1'b0, 32'h1c000600, 7'h7F, 1'b1, 32'h1c00e000, 32'h1c00f000, 1'b1);
    #1;
    vectors++; if (wb_ex !== 1'b0 || ertn_flush !== 1'b0 || flush_all !== 1'b0 || commit_ok !== 1'b0) begin miscompares++; $display("FAIL quiet_idle: got ex=%b er=%b fl=%b ok=%b expected 0/0/0/0", wb_ex, ertn_flush, flush_all, commit_ok); end
    tick();
    #1;
    vectors++; if (rvalid !== 1'b0 || cnt !== start) begin miscompares++; $display("FAIL quiet_no_redirect: got rv=%b cnt=%0d expected 0/%0d", rvalid, cnt, start); end
  endtask

  task automatic test_random();
    logic       e_ex, e_er, e_ok, e_fl;
    logic [5:0] e_ec;
    logic [8:0] e_sb;
    logic [31:0] e_epc;
    logic [6:0] f;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0:       f = 7'($urandom);
        1:       f = 7'(1 << $urandom_range(0, 6));
        default: f = 7'h0;
      endcase
      drive($urandom_range(0, 9) < 7, $urandom, f, $urandom_range(0, 4) == 0,
            $urandom, $urandom, $urandom_range(0, 3) != 0);
      #1;
      e_ex  = !m_redir && wb_valid && (f != 0);
      e_er  = !m_redir && wb_valid && wb_is_ertn && (f == 0);
      e_ok  = !m_redir && wb_valid && (f == 0);
      e_fl  = m_redir || e_ex || e_er;
      e_ec  = e_ex ? ref_ecode(f) : 6'h0;
      e_sb  = e_ex ? ref_esub(f)  : 9'h0;
      e_epc = m_redir ? 32'h0 : wb_pc;
      vectors++; if (wb_ex !== e_ex || ertn_flush !== e_er) begin miscompares++; $display("FAIL rnd_events@%0d: got ex=%b er=%b expected %b/%b", n, wb_ex, ertn_flush, e_ex, e_er); end
      vectors++; if (ecode !== e_ec || esub !== e_sb) begin miscompares++; $display("FAIL rnd_codes@%0d: got %h/%h expected %h/%h", n, ecode, esub, e_ec, e_sb); end
      vectors++; if (commit_ok !== e_ok || flush_all !== e_fl) begin miscompares++; $display("FAIL rnd_ok_flush@%0d: got %b/%b expected %b/%b", n, commit_ok, flush_all, e_ok, e_fl); end
      vectors++; if (epc !== e_epc) begin miscompares++; $display("FAIL rnd_epc@%0d: got %h expected %h", n, epc, e_epc); end
      vectors++; if (rvalid !== m_redir || rpc !== m_pc) begin miscompares++; $display("FAIL rnd_redirect@%0d: got %b/%h expected %b/%h", n, rvalid, rpc, m_redir, m_pc); end
      vectors++; if (cnt !== ref_cnt()) begin miscompares++; $display("FAIL rnd_count@%0d: got %0d expected %0d", n, cnt, ref_cnt()); end
      tick();
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_syscall();
    test_priority();
    test_ertn();
    test_backpressure();
    test_async_reset();
    test_wrap_idle();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_wb_exc_commit
`default_nettype wire
